// File: rtl/sram_pkg.sv
// Shared SRAM access definitions: arbiter state encoding, cycle counter type and
// timing defaults used by the arbiter and the address counter.
package sram_pkg;

    localparam int WR_PULSE_CYCLES_DEF = 1;
    localparam int RD_WAIT_CYCLES_DEF  = 1;
    localparam int CYC_CNT_W           = 4;
    localparam int SRAM_DATA_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OEOFF  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_WREND  = 3'd3,
        ST_RDWAIT = 3'd4,
        ST_RDCAP  = 3'd5,
        ST_INC    = 3'd6
    } arb_state_e;

    typedef logic [CYC_CNT_W-1:0] cyc_cnt_t;

    function automatic cyc_cnt_t to_cyc_cnt(input int cycles);
        return cyc_cnt_t'(cycles);
    endfunction

endpackage

// File: rtl/sram_access_arbiter.sv
// Arbitrates acquisition writes, MCU writes and MCU reads onto one asynchronous
// SRAM, sequencing OE/WE/bus-drive so the data bus is never contended.
module sram_access_arbiter
    import sram_pkg::*;
#(
    parameter int WR_PULSE_CYCLES = WR_PULSE_CYCLES_DEF,
    parameter int RD_WAIT_CYCLES  = RD_WAIT_CYCLES_DEF
) (
    input  logic                   CLK_MASTER,
    input  logic                   RESET,
    input  logic                   ACQ_WR_REQ,
    input  logic [SRAM_DATA_W-1:0] ACQ_WR_DATA,
    input  logic                   MCU_WR_REQ,
    input  logic                   MCU_RD_REQ,
    input  logic [SRAM_DATA_W-1:0] MCU_WR_DATA,
    input  logic                   SR_FULL,
    input  logic                   CLR_OVERFLOW,
    input  logic [SRAM_DATA_W-1:0] SRAM_DQ_IN,
    output logic [SRAM_DATA_W-1:0] SRAM_DQ_OUT,
    output logic                   SRAM_DQ_OE,
    output logic                   SRAM_WE_n,
    output logic                   SRAM_OE_n,
    output logic                   ADDR_INC,
    output logic [SRAM_DATA_W-1:0] RD_DATA,
    output logic                   RD_VALID,
    output logic                   BUSY,
    output logic                   OVERFLOW
);

    localparam cyc_cnt_t WR_CNT_INIT = to_cyc_cnt(WR_PULSE_CYCLES);
    localparam cyc_cnt_t RD_CNT_INIT = to_cyc_cnt(RD_WAIT_CYCLES);
    localparam cyc_cnt_t CNT_LAST    = to_cyc_cnt(1);

    arb_state_e             state_q;
    cyc_cnt_t               cnt_q;
    logic                   acq_pend_q,  acq_pend_d;
    logic                   mcuw_pend_q, mcuw_pend_d;
    logic                   mcur_pend_q, mcur_pend_d;
    logic [SRAM_DATA_W-1:0] acq_data_q,  acq_data_d;
    logic [SRAM_DATA_W-1:0] mcuw_data_q, mcuw_data_d;
    logic                   overflow_q,  overflow_d;
    logic [SRAM_DATA_W-1:0] dq_out_q;
    logic [SRAM_DATA_W-1:0] rd_data_q;
    logic                   dq_oe_q;
    logic                   we_n_q;
    logic                   oe_n_q;
    logic                   addr_inc_q;
    logic                   rd_valid_q;
    logic                   busy_q;

    logic                   in_idle;
    logic                   acq_take;
    logic                   acq_drop;
    logic                   grant_acq;
    logic                   grant_mcuw;
    logic                   grant_mcur;
    logic [SRAM_DATA_W-1:0] wr_data_sel;

    // An acquisition pulse is only queued when the buffer has room and no
    // earlier acquisition byte is still waiting; otherwise the byte is lost.
    assign in_idle    = (state_q == ST_IDLE);
    assign acq_take   = ACQ_WR_REQ && !SR_FULL && !acq_pend_q;
    assign acq_drop   = ACQ_WR_REQ && (SR_FULL || acq_pend_q);
    assign grant_acq  = in_idle && (acq_pend_q || acq_take);
    assign grant_mcuw = in_idle && !grant_acq && (mcuw_pend_q || MCU_WR_REQ);
    assign grant_mcur = in_idle && !grant_acq && !grant_mcuw && (mcur_pend_q || MCU_RD_REQ);

    always_comb begin
        acq_pend_d  = acq_pend_q;
        mcuw_pend_d = mcuw_pend_q;
        mcur_pend_d = mcur_pend_q;
        acq_data_d  = acq_data_q;
        mcuw_data_d = mcuw_data_q;
        wr_data_sel = '0;

        if (grant_acq) begin
            acq_pend_d = 1'b0;
        end else if (acq_take) begin
            acq_pend_d = 1'b1;
            acq_data_d = ACQ_WR_DATA;
        end

        // A repeated MCU pulse while one is pending keeps the original byte.
        if (grant_mcuw) begin
            mcuw_pend_d = 1'b0;
        end else if (MCU_WR_REQ && !mcuw_pend_q) begin
            mcuw_pend_d = 1'b1;
            mcuw_data_d = MCU_WR_DATA;
        end

        if (grant_mcur) begin
            mcur_pend_d = 1'b0;
        end else if (MCU_RD_REQ) begin
            mcur_pend_d = 1'b1;
        end

        if (grant_acq) begin
            wr_data_sel = acq_pend_q ? acq_data_q : ACQ_WR_DATA;
        end else begin
            wr_data_sel = mcuw_pend_q ? mcuw_data_q : MCU_WR_DATA;
        end

        overflow_d = (overflow_q && !CLR_OVERFLOW) || acq_drop;
    end

    always_ff @(posedge CLK_MASTER) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acq_pend_q  <= 1'b0;
            mcuw_pend_q <= 1'b0;
            mcur_pend_q <= 1'b0;
            acq_data_q  <= '0;
            mcuw_data_q <= '0;
            overflow_q  <= 1'b0;
            dq_out_q    <= '0;
            rd_data_q   <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b0;
            addr_inc_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            acq_pend_q  <= acq_pend_d;
            mcuw_pend_q <= mcuw_pend_d;
            mcur_pend_q <= mcur_pend_d;
            acq_data_q  <= acq_data_d;
            mcuw_data_q <= mcuw_data_d;
            overflow_q  <= overflow_d;
            addr_inc_q  <= 1'b0;
            rd_valid_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // Turn the SRAM output off in the same edge the bus is taken,
                    // so WE only falls a full cycle after the bus is driven.
                    if (grant_acq || grant_mcuw) begin
                        state_q  <= ST_OEOFF;
                        oe_n_q   <= 1'b1;
                        dq_oe_q  <= 1'b1;
                        dq_out_q <= wr_data_sel;
                        busy_q   <= 1'b1;
                    end else if (grant_mcur) begin
                        state_q <= ST_RDWAIT;
                        oe_n_q  <= 1'b0;
                        cnt_q   <= RD_CNT_INIT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_OEOFF: begin
                    state_q <= ST_WRITE;
                    we_n_q  <= 1'b0;
                    cnt_q   <= WR_CNT_INIT;
                end
                ST_WRITE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_WREND;
                        we_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_WREND: begin
                    state_q    <= ST_INC;
                    addr_inc_q <= 1'b1;
                end
                ST_RDWAIT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q    <= ST_RDCAP;
                        rd_data_q  <= SRAM_DQ_IN;
                        rd_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RDCAP: begin
                    state_q    <= ST_INC;
                    addr_inc_q <= 1'b1;
                end
                ST_INC: begin
                    state_q <= ST_IDLE;
                    oe_n_q  <= 1'b0;
                    dq_oe_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    oe_n_q  <= 1'b0;
                    dq_oe_q <= 1'b0;
                    we_n_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign SRAM_DQ_OUT = dq_out_q;
    assign SRAM_DQ_OE  = dq_oe_q;
    assign SRAM_WE_n   = we_n_q;
    assign SRAM_OE_n   = oe_n_q;
    assign ADDR_INC    = addr_inc_q;
    assign RD_DATA     = rd_data_q;
    assign RD_VALID    = rd_valid_q;
    assign BUSY        = busy_q;
    assign OVERFLOW    = overflow_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: a transaction-level reference model
// predicts served operations; a monitor checks them as the SRAM bus shows them.
module tb_sram_access_arbiter;

    localparam int WR_P = 3;
    localparam int RD_W = 2;
    localparam int WR_LEN = WR_P + 3;  // OE off, WE pulse, WE release, increment
    localparam int RD_LEN = RD_W + 2;  // OE wait, capture, increment

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       ACQ_WR_REQ = 1'b0;
    logic [7:0] ACQ_WR_DATA = '0;
    logic       MCU_WR_REQ = 1'b0;
    logic       MCU_RD_REQ = 1'b0;
    logic [7:0] MCU_WR_DATA = '0;
    logic       SR_FULL = 1'b0;
    logic       CLR_OVERFLOW = 1'b0;
    logic [7:0] SRAM_DQ_IN;
    logic [7:0] SRAM_DQ_OUT;
    logic       SRAM_DQ_OE, SRAM_WE_n, SRAM_OE_n, ADDR_INC, RD_VALID, BUSY, OVERFLOW;
    logic [7:0] RD_DATA;

    always #5 clk = ~clk;

    sram_access_arbiter #(.WR_PULSE_CYCLES(WR_P), .RD_WAIT_CYCLES(RD_W)) u_dut (
        .CLK_MASTER  (clk),
        .RESET       (RESET),
        .ACQ_WR_REQ  (ACQ_WR_REQ),
        .ACQ_WR_DATA (ACQ_WR_DATA),
        .MCU_WR_REQ  (MCU_WR_REQ),
        .MCU_RD_REQ  (MCU_RD_REQ),
        .MCU_WR_DATA (MCU_WR_DATA),
        .SR_FULL     (SR_FULL),
        .CLR_OVERFLOW(CLR_OVERFLOW),
        .SRAM_DQ_IN  (SRAM_DQ_IN),
        .SRAM_DQ_OUT (SRAM_DQ_OUT),
        .SRAM_DQ_OE  (SRAM_DQ_OE),
        .SRAM_WE_n   (SRAM_WE_n),
        .SRAM_OE_n   (SRAM_OE_n),
        .ADDR_INC    (ADDR_INC),
        .RD_DATA     (RD_DATA),
        .RD_VALID    (RD_VALID),
        .BUSY        (BUSY),
        .OVERFLOW    (OVERFLOW)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- external SRAM and address counter ----------------
    logic [7:0] sram_mem [256];
    logic [7:0] sram_addr;
    logic       pre_en = 1'b0;
    logic [7:0] pre_addr = '0;
    logic [7:0] pre_val = '0;

    always @(posedge clk) begin
        if (pre_en) sram_mem[pre_addr] <= pre_val;
        else if (!SRAM_WE_n) sram_mem[sram_addr] <= SRAM_DQ_OUT;
    end
    always @(posedge clk) begin
        if (RESET) sram_addr <= '0;
        else if (ADDR_INC) sram_addr <= sram_addr + 8'd1;
    end
    assign SRAM_DQ_IN = SRAM_OE_n ? 8'hFF : sram_mem[sram_addr];

    // ---------------- reference model ----------------
    typedef struct packed {
        bit         is_rd;
        logic [7:0] data;
    } op_t;

    op_t        op_q[$];
    int         inc_q[$];
    logic [7:0] model_mem [256];
    int         m_addr = 0;
    int         m_rem = 0;
    int         m_ops = 0;
    bit         p_acq = 0, p_mw = 0, p_mr = 0, m_ovf = 0;
    logic [7:0] d_acq = '0, d_mw = '0;

    // Served operations run back to back; each one occupies the SRAM for a fixed
    // number of cycles and consumes the next address.
    task automatic model_step(input bit acq, input logic [7:0] ad, input bit mw,
                              input logic [7:0] md, input bit mr, input bit full,
                              input bit clr, input bit rst);
        bit         idle;
        bit         new_acq;
        int         src;
        logic [7:0] wdata;
        if (rst) begin
            p_acq = 0; p_mw = 0; p_mr = 0; m_ovf = 0;
            m_rem = 0; m_addr = 0; m_ops = 0;
            op_q.delete();
            inc_q.delete();
            return;
        end
        idle    = (m_rem == 0);
        if (!idle) m_rem--;
        new_acq = acq && !full && !p_acq;
        m_ovf   = (m_ovf && !clr) || (acq && (full || p_acq));
        src     = 0;
        wdata   = '0;
        if (idle) begin
            if (p_acq || new_acq) src = 1;
            else if (p_mw || mw)  src = 2;
            else if (p_mr || mr)  src = 3;
        end
        if (src == 1) begin wdata = p_acq ? d_acq : ad; p_acq = 0; end
        else if (new_acq) begin p_acq = 1; d_acq = ad; end
        if (src == 2) begin wdata = p_mw ? d_mw : md; p_mw = 0; end
        else if (mw && !p_mw) begin p_mw = 1; d_mw = md; end
        if (src == 3) p_mr = 0;
        else if (mr) p_mr = 1;
        if (src == 1 || src == 2) begin
            model_mem[m_addr] = wdata;
            op_q.push_back('{is_rd: 1'b0, data: wdata});
            m_rem = WR_LEN;
        end else if (src == 3) begin
            op_q.push_back('{is_rd: 1'b1, data: model_mem[m_addr]});
            m_rem = RD_LEN;
        end
        if (src != 0) begin
            inc_q.push_back(cyc + m_rem);  // increment visible in the op's last busy cycle
            m_addr = (m_addr + 1) % 256;
            m_ops++;
        end
    endtask

    task automatic tick(input bit acq, input logic [7:0] ad, input bit mw, input logic [7:0] md,
                        input bit mr, input bit full, input bit clr, input bit rst);
        ACQ_WR_REQ = acq; ACQ_WR_DATA = ad;
        MCU_WR_REQ = mw;  MCU_WR_DATA = md;
        MCU_RD_REQ = mr;  SR_FULL = full;
        CLR_OVERFLOW = clr; RESET = rst;
        model_step(acq, ad, mw, md, mr, full, clr, rst);
        @(negedge clk);
        chk("busy", BUSY, m_rem > 0);
        chk("overflow", OVERFLOW, m_ovf);
    endtask

    task automatic idle_tick();
        tick(0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((m_rem != 0 || p_acq || p_mw || p_mr) && n < 300) begin
            idle_tick();
            n++;
        end
        repeat (3) idle_tick();
        chk({tag, "_drain_in_time"}, n < 300, 1);
        chk({tag, "_inc_count"}, inc_cnt, m_ops);
        chk({tag, "_ops_left"}, op_q.size(), 0);
    endtask

    // ---------------- monitor (samples 1 time unit after each edge) ----------------
    logic rst_seen = 1'b1;
    int   inc_cnt = 0;
    always @(posedge clk) rst_seen <= RESET;

    initial begin
        int   we_run = 0;
        int   oe_run = 0;
        logic prev_we_n = 1'b1;
        logic prev_dq_oe = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_seen) begin
                we_run = 0; oe_run = 0; inc_cnt = 0;
                prev_we_n = 1'b1; prev_dq_oe = 1'b0;
            end else begin
                chk("dq_oe_while_oe_low", SRAM_DQ_OE && !SRAM_OE_n, 0);
                if (!SRAM_WE_n) begin
                    we_run++;
                    chk("we_low_after_dq_oe", prev_dq_oe, 1);
                    chk("wr_expected", (op_q.size() > 0) && !op_q[0].is_rd, 1);
                    if (op_q.size() > 0) chk("wr_data", SRAM_DQ_OUT, op_q[0].data);
                end
                if (SRAM_WE_n && !prev_we_n) begin
                    chk("we_pulse_len", we_run, WR_P);
                    we_run = 0;
                    if (op_q.size() > 0) void'(op_q.pop_front());
                end
                if (RD_VALID) begin
                    chk("rd_expected", (op_q.size() > 0) && op_q[0].is_rd, 1);
                    chk("rd_oe_wait", oe_run, RD_W);
                    if (op_q.size() > 0) begin
                        chk("rd_data", RD_DATA, op_q[0].data);
                        void'(op_q.pop_front());
                    end
                    oe_run = 0;
                end else if (BUSY && !SRAM_OE_n && !ADDR_INC) begin
                    oe_run++;
                end else begin
                    oe_run = 0;
                end
                if (ADDR_INC) begin
                    inc_cnt++;
                    chk("inc_expected", inc_q.size() > 0, 1);
                    if (inc_q.size() > 0) chk("inc_cycle", cyc, inc_q.pop_front());
                end
                prev_we_n  = SRAM_WE_n;
                prev_dq_oe = SRAM_DQ_OE;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit full_r;
        int guard;
        model_step(0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
        @(negedge clk);
        for (int a = 0; a < 256; a++) begin
            pre_en = 1'b1;
            pre_addr = 8'(a);
            pre_val = 8'($urandom);
            model_mem[a] = pre_val;
            @(negedge clk);
        end
        pre_en = 1'b0;
        idle_tick();

        chk("rst_we_n", SRAM_WE_n, 1);
        chk("rst_oe_n", SRAM_OE_n, 0);
        chk("rst_dq_oe", SRAM_DQ_OE, 0);
        chk("rst_addr_inc", ADDR_INC, 0);
        chk("rst_rd_valid", RD_VALID, 0);
        chk("rst_rd_data", RD_DATA, 8'h00);
        chk("rst_dq_out", SRAM_DQ_OUT, 8'h00);

        // single acquisition write
        tick(1, 8'hA5, 0, 8'h00, 0, 0, 0, 0);
        drain("single_wr");
        chk("single_wr_dq_out", SRAM_DQ_OUT, 8'hA5);

        // write and read requested on the same edge; read address holds 0x3C
        pre_en = 1'b1; pre_addr = 8'((m_addr + 1) % 256); pre_val = 8'h3C;
        model_mem[(m_addr + 1) % 256] = 8'h3C;
        idle_tick();
        pre_en = 1'b0;
        tick(1, 8'h5A, 0, 8'h00, 1, 0, 0, 0);
        drain("wr_then_rd");
        chk("wr_then_rd_data", RD_DATA, 8'h3C);

        // acquisition writes while the buffer is full
        for (int i = 0; i < 3; i++) begin
            tick(1, 8'(i + 1), 0, 8'h00, 0, 1, 0, 0);
            idle_tick();
        end
        chk("full_overflow_set", OVERFLOW, 1);
        tick(0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
        chk("full_overflow_cleared", OVERFLOW, 0);
        tick(1, 8'h44, 0, 8'h00, 0, 1, 0, 0);
        tick(1, 8'h45, 0, 8'h00, 0, 1, 1, 0);
        chk("clr_and_event_same_edge", OVERFLOW, 1);
        tick(0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
        drain("full");

        // MCU write coalescing and read-after-write
        tick(0, 8'h00, 1, 8'hC1, 0, 0, 0, 0);
        tick(0, 8'h00, 1, 8'hC2, 1, 0, 0, 0);
        tick(0, 8'h00, 1, 8'hC3, 1, 0, 0, 0);
        drain("mcu_mix");

        // reset in the middle of a write with an MCU write pending
        tick(1, 8'h77, 0, 8'h00, 0, 0, 0, 0);
        tick(0, 8'h00, 1, 8'h12, 0, 0, 0, 0);
        guard = 0;
        while (SRAM_WE_n && guard < 10) begin
            idle_tick();
            guard++;
        end
        chk("abort_reached_write", SRAM_WE_n, 0);
        tick(0, 8'h00, 0, 8'h00, 0, 0, 0, 1);
        chk("abort_we_n", SRAM_WE_n, 1);
        chk("abort_dq_oe", SRAM_DQ_OE, 0);
        chk("abort_addr_inc", ADDR_INC, 0);
        chk("abort_dq_out", SRAM_DQ_OUT, 8'h00);
        chk("abort_rd_data", RD_DATA, 8'h00);
        repeat (20) idle_tick();
        chk("abort_no_inc", inc_cnt, 0);

        // randomized mixed traffic
        full_r = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 199) == 0) full_r = !full_r;
            tick($urandom_range(0, 6) == 0, 8'($urandom),
                 $urandom_range(0, 9) == 0, 8'($urandom),
                 $urandom_range(0, 9) == 0, full_r,
                 $urandom_range(0, 49) == 0, 0);
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
